// File: rtl/mac_pipe.sv
// Pipelined unsigned multiply-accumulate (A*B + C, or first/last framed dot product)
// with valid/ready on both sides. Optional saturation: define MAC_PIPE_SAT_EN.
module mac_pipe #(
  parameter  int W  = 8,
  parameter  int G  = 4,
  localparam int AW = 2 * W + G
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [2*W-1:0]  in_c,
  input  logic            in_first,
  input  logic            in_last,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [AW-1:0]   out_data,
  output logic            out_ovf,
  output logic            out_valid,
  input  logic            out_ready
);

  // Handshake: a beat moves on an edge where in_valid && in_ready; a result
  // leaves on an edge where out_valid && out_ready. One global enable stalls
  // every stage (valids, data, accumulator) while a result is held.
  logic en;

  // Stage 1: registered inputs
  logic [W-1:0]   s1_a_q, s1_a_d;
  logic [W-1:0]   s1_b_q, s1_b_d;
  logic [2*W-1:0] s1_c_q, s1_c_d;
  logic           s1_first_q, s1_first_d;
  logic           s1_last_q, s1_last_d;
  logic           s1_valid_q, s1_valid_d;

  // Stage 2: exact product
  logic [2*W-1:0] s2_p_q, s2_p_d;
  logic [2*W-1:0] s2_c_q, s2_c_d;
  logic           s2_first_q, s2_first_d;
  logic           s2_last_q, s2_last_d;
  logic           s2_valid_q, s2_valid_d;

  // Stage 3: accumulator and the finished result waiting for the output register
  logic [AW-1:0]  acc_q, acc_d;
  logic [AW-1:0]  res_data_q, res_data_d;
  logic           res_valid_q, res_valid_d;

  // Output register
  logic [AW-1:0]  out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;

  logic [AW-1:0]  base;
  logic [AW-1:0]  p_ext;
  logic [AW-1:0]  sum;

`ifdef MAC_PIPE_SAT_EN
  logic           acc_ovf_q, acc_ovf_d;
  logic           res_ovf_q, res_ovf_d;
  logic           out_ovf_q, out_ovf_d;
  logic [AW:0]    sum_full;
  logic           ovf_now;
`endif

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_valid_d = s1_valid_q;
    if (en) begin
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_c_d     = in_c;
      s1_first_d = in_first;
      s1_last_d  = in_last;
      s1_valid_d = in_valid;
    end
  end

  always_comb begin
    s2_p_d     = s2_p_q;
    s2_c_d     = s2_c_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    s2_valid_d = s2_valid_q;
    if (en) begin
      s2_p_d     = {{W{1'b0}}, s1_a_q} * {{W{1'b0}}, s1_b_q};
      s2_c_d     = s1_c_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_valid_d = s1_valid_q;
    end
  end

  assign base  = s2_first_q ? {{G{1'b0}}, s2_c_q} : acc_q;
  assign p_ext = {{G{1'b0}}, s2_p_q};

`ifdef MAC_PIPE_SAT_EN
  // Clamp on carry-out; the flag stays set until the next first beat.
  assign sum_full = {1'b0, base} + {1'b0, p_ext};
  assign sum      = sum_full[AW] ? {AW{1'b1}} : sum_full[AW-1:0];
  assign ovf_now  = sum_full[AW] || (!s2_first_q && acc_ovf_q);
`else
  assign sum = base + p_ext;
`endif

  always_comb begin
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
`ifdef MAC_PIPE_SAT_EN
    acc_ovf_d   = acc_ovf_q;
    res_ovf_d   = res_ovf_q;
`endif
    if (en) begin
      res_valid_d = 1'b0;
      if (s2_valid_q) begin
        acc_d = sum;
`ifdef MAC_PIPE_SAT_EN
        acc_ovf_d = ovf_now;
`endif
        if (s2_last_q) begin
          res_valid_d = 1'b1;
          res_data_d  = sum;
`ifdef MAC_PIPE_SAT_EN
          res_ovf_d   = ovf_now;
`endif
        end
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef MAC_PIPE_SAT_EN
    out_ovf_d   = out_ovf_q;
`endif
    if (en) begin
      out_valid_d = res_valid_q;
      if (res_valid_q) begin
        out_data_d = res_data_q;
`ifdef MAC_PIPE_SAT_EN
        out_ovf_d  = res_ovf_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_p_q      <= '0;
      s2_c_q      <= '0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_valid_q  <= s1_valid_d;
      s2_p_q      <= s2_p_d;
      s2_c_q      <= s2_c_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_valid_q  <= s2_valid_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MAC_PIPE_SAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_ovf_q <= 1'b0;
      res_ovf_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      acc_ovf_q <= acc_ovf_d;
      res_ovf_q <= res_ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  assign out_ovf = out_ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: directed scenarios plus random traffic, checked against an
// arithmetic reference model through an expected-result queue.
module tb_mac_pipe;
  localparam int W  = 8;
  localparam int G  = 4;
  localparam int AW = 2 * W + G;
  localparam longint MAXV = (longint'(1) << AW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic [2*W-1:0]  in_c;
  logic            in_first;
  logic            in_last;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   out_data;
  logic            out_ovf;
  logic            out_valid;
  logic            out_ready;

  // clock / reset
  always #5 clk = ~clk;

  mac_pipe #(.W(W), .G(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_first(in_first), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  // scoreboard: {ovf, data} per expected result
  logic [AW:0] exp_q[$];
  logic [AW:0] last_out = '0;
  logic [AW:0] held     = '0;
  bit          hold_pending = 0;
  longint      acc_m = 0;
  bit          ovf_m = 0;
  bit          rand_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // reference model: operates on the accepted beat with plain integer arithmetic
  task automatic model_beat(input int a, input int b, input int c, input bit first, input bit last);
    longint s;
    bit     o;
    s = (first ? longint'(c) : acc_m) + longint'(a) * longint'(b);
    o = 0;
`ifdef MAC_PIPE_SAT_EN
    if (s > MAXV) begin
      s = MAXV;
      o = 1;
    end
    ovf_m = first ? o : (ovf_m | o);
`else
    s = s % (MAXV + 1);
    ovf_m = 0;
`endif
    acc_m = s;
    if (last) exp_q.push_back({ovf_m, AW'(acc_m)});
  endtask

  // driver: called at a negedge, returns at a negedge
  task automatic send_beat(input int a, input int b, input int c, input bit first, input bit last);
    bit ok;
    bit rdy;
    in_a     = W'(a);
    in_b     = W'(b);
    in_c     = (2*W)'(c);
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      #2;
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    else model_beat(a, b, c, first, last);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2000; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // scoreboard monitor: results are consumed on edges with out_valid && out_ready
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 0;
    end else begin
      check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (hold_pending) begin
        check("hold_valid", {31'b0, out_valid}, 1);
        check("hold_data", {11'b0, out_ovf, out_data}, {11'b0, held});
      end
      hold_pending = out_valid && !out_ready;
      held = {out_ovf, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_while_none_expected", {31'b0, out_valid}, 0);
        else check("result", {11'b0, out_ovf, out_data}, {11'b0, exp_q.pop_front()});
        n_out++;
        last_out = {out_ovf, out_data};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit ok;
    rst_n = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    in_first = 1'b0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {12'b0, out_data}, 0);
    check("rst_out_ovf", {31'b0, out_ovf}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 1);

    // fused multiply-add with latency check
    send_beat(200, 100, 55, 1, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("fma_not_early", {31'b0, out_valid}, 0);
    @(negedge clk);
    check("fma_valid_t3", {31'b0, out_valid}, 1);
    check("fma_data", {12'b0, out_data}, 20055);
    check("fma_ovf", {31'b0, out_ovf}, 0);
    drain();

    // 4-beat burst
    n0 = n_out;
    for (int i = 0; i < 4; i++) send_beat(255, 255, (i == 0) ? 1 : 0, i == 0, i == 3);
    drain();
    check("burst_one_output", n_out - n0, 1);
    check("burst_data", {11'b0, last_out}, 260101);

    // back-pressure mid-stream
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(i, 2, 0, 1, 1);
      end
      begin
        ok = 0;
        for (int k = 0; k < 100; k++) begin
          @(posedge clk);
          #1;
          if (out_valid) begin
            ok = 1;
            break;
          end
        end
        if (!ok) check("bp_wait_timeout", 0, 1);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready_low", {31'b0, in_ready}, 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - n0, 6);
    check("bp_last", {11'b0, last_out}, 10);

    // 17-beat overflow burst
    for (int i = 0; i < 17; i++) send_beat(255, 255, 0, i == 0, i == 16);
    drain();
`ifdef MAC_PIPE_SAT_EN
    check("ovf_data", {12'b0, last_out[AW-1:0]}, 1048575);
    check("ovf_flag", {31'b0, last_out[AW]}, 1);
`else
    check("ovf_data", {12'b0, last_out[AW-1:0]}, 56849);
    check("ovf_flag", {31'b0, last_out[AW]}, 0);
`endif

    // reset mid-burst
    n0 = n_out;
    send_beat(10, 10, 0, 1, 0);
    send_beat(10, 10, 0, 0, 0);
    rst_n = 1'b0;
    acc_m = 0;
    ovf_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst2_out_valid", {31'b0, out_valid}, 0);
    check("rst2_in_ready", {31'b0, in_ready}, 1);
    send_beat(3, 4, 5, 1, 1);
    drain();
    check("rst2_count", n_out - n0, 1);
    check("rst2_data", {11'b0, last_out}, 17);

    // gapped burst
    for (int i = 0; i < 3; i++) begin
      send_beat(2, 3, 7, i == 0, i == 2);
      if (i < 2) repeat (2) @(negedge clk);
    end
    drain();
    check("gap_data", {11'b0, last_out}, 25);

    // random traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
          if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_pipe.md
# mac_pipe

Parametrised, pipelined unsigned multiply-accumulate unit with valid/ready handshakes on both sides. It computes either a single fused multiply-add, A·B + C, or a multi-beat dot-product accumulation framed by first/last markers. It is the general datapath building block for the exercise designs: a 3-stage pipeline with back-pressure and optional saturation.

## Interface

Parameters:
- `W`, default 8: operand width of `in_a` and `in_b`.
- `G`, default 4: accumulator guard bits.
- `AW`: derived, AW = 2·W + G, the accumulator and result width. Not overridable.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `in_a`  in  W  multiplicand, unsigned.
- `in_b`  in  W  multiplier, unsigned.
- `in_c`  in  2W  addend, unsigned; used only on a first beat.
- `in_first`  in  1  beat starts a new accumulation.
- `in_last`  in  1  beat ends the accumulation and produces a result.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  unit accepts a beat this cycle.
- `out_data`  out  AW  result.
- `out_ovf`  out  1  result overflowed (see Configuration).
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.

## Operation

- A beat is accepted when `in_valid && in_ready`.
- Pipeline enable: `en = !out_valid || out_ready`. `in_ready = en`. When `en` = 0 every stage holds, including valid bits, data, and accumulator.
- S1 (when en): register a, b, c, first, last, and valid (= accepted).
- S2 (when en): P = a·b (2W bits, exact); pass c, first, last, and valid.
- S3 (when en and S2 valid):
  - sum = (first ? zero-extended c : acc) + zero-extended P, computed in AW bits.
  - acc ← sum.
  - If last: out_data ← sum and out_valid ← 1.
- S3 (when en and S2 invalid): acc is unchanged.
- When en holds and no new result is loaded, out_valid ← 0 after the result is taken.
- Fused multiply-add mode is a beat with first = last = 1.
- A burst has exactly one out_valid, on its last beat. Intermediate beats produce no output.
- A beat with first = 0 after a completed burst continues from the retained acc. This is defined behaviour, not an error.
- first and last on adjacent back-to-back bursts need no idle cycle.
- in_valid = 0 cycles inside a burst are legal and leave acc untouched.
- Reset (rst_n = 0 at an edge), all outputs and state cleared:
  - out_valid = 0, out_data = 0, out_ovf = 0, acc = 0.
  - All stage valids = 0.
  - in_ready = 1 after reset.
- Reset mid-burst discards in-flight beats and partial acc; no output is produced for that burst.

## Timing

- Latency: a beat accepted at edge t reaches S3 at edge t+2. For a last beat, out_valid = 1 after edge t+3, assuming no stall.
- Throughput is one beat per cycle while out_ready = 1.
- out_data and out_ovf are stable while out_valid = 1 and out_ready = 0.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_* to out_*.
- Simultaneous result handoff and new result load in the same cycle is allowed; there is no bubble.

## Configuration

- Macro `MAC_PIPE_SAT_EN`.
- Defined:
  - If the true sum exceeds 2^AW − 1, acc and out_data clamp to 2^AW − 1.
  - out_ovf = 1 for that result.
  - The overflow state is sticky for the rest of the burst and cleared on the next first beat.
- Undefined:
  - The sum wraps modulo 2^AW.
  - out_ovf is tied to 0.
  - No comparator logic is instantiated.

## Test plan

All scenarios use W = 8, G = 4 (AW = 20).

- **Fused multiply-add:** A = 200, B = 100, C = 55, first = last = 1 at edge t -> out_valid at t+3, out_data = 20055, out_ovf = 0.
- **Burst:** 4 consecutive beats A = B = 255, C = 1 on beat 0, first on beat 0, last on beat 3 -> exactly one out_valid, out_data = 260101.
- **Back-pressure:** stream 6 single-beat fused multiply-adds (A = i, B = 2, C = 0) with out_ready low for 5 cycles mid-stream -> in_ready low while the output is held, out_data stable. Results 0, 2, 4, 6, 8, 10 arrive in order with no loss or duplication.
- **Overflow:** 17-beat burst A = B = 255, C = 0 -> with `MAC_PIPE_SAT_EN`: out_data = 1048575, out_ovf = 1. Without: out_data = 56849, out_ovf = 0.
- **Reset mid-burst:** 2 beats of A = B = 10 (first on beat 0, no last), rst_n low for 1 cycle, then a fused multiply-add A = 3, B = 4, C = 5 -> the only output is 17, with no output from the aborted burst.
- **Gapped burst:** 3 beats A = 2, B = 3, C = 7 with 2 idle cycles between beats -> out_data = 25.
